copy_array_split_param: RTL and testbench

COPY_ARRAY_SPLIT_PARAM -- requirements
Module: copy_array_split_param

---
 rtl/copy_array_split_param.sv | 145 ++++++++++++++
 tb/tb_copy_array_split_param.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/copy_array_split_param.sv
`default_nettype none
// ============================================================================
// Module      : copy_array_split_param
// Description : Copies array M into N through an external one-port interface,
//               either rotated to start at the first element >= Thresh or
//               reversed, and counts the elements >= Thresh.
// Revision    : 1.0 - initial release
// ============================================================================
module copy_array_split_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Ack,
    input  logic             Mode,
    input  logic [WIDTH-1:0] Thresh,
    input  logic [WIDTH-1:0] Ms_of_I,
    output logic [AW-1:0]    I,
    output logic [AW-1:0]    J,
    output logic             Ns_of_J_Write,
    output logic             Done,
    output logic [AW:0]      Hi_Count
);

    localparam logic [2:0]    c_ST_INI  = 3'd0;
    localparam logic [2:0]    c_ST_SCAN = 3'd1;
    localparam logic [2:0]    c_ST_COPY = 3'd2;
    localparam logic [2:0]    c_ST_REV  = 3'd3;
    localparam logic [2:0]    c_ST_DONE = 3'd4;
    localparam logic [AW-1:0] c_LAST    = AW'(DEPTH - 1);

    logic [2:0]       r_state, w_state_nxt;
    logic [AW-1:0]    r_i, w_i_nxt;
    logic [AW-1:0]    r_j, w_j_nxt;
    logic [AW:0]      r_hi, w_hi_nxt;
    logic [WIDTH-1:0] r_thresh, w_thresh_nxt;
    logic             w_match;
    logic             w_write;
    logic             w_done;

    // Index arithmetic stays inside 0..DEPTH-1 even when DEPTH < 2**AW
    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] x);
        return (x == c_LAST) ? '0 : x + AW'(1);
    endfunction

    function automatic logic [AW-1:0] f_dec(input logic [AW-1:0] x);
        return (x == '0) ? c_LAST : x - AW'(1);
    endfunction

    assign w_match = (Ms_of_I >= r_thresh);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= c_ST_INI;
            r_i      <= '0;
            r_j      <= '0;
            r_hi     <= '0;
            r_thresh <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_hi     <= w_hi_nxt;
            r_thresh <= w_thresh_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_i_nxt      = r_i;
        w_j_nxt      = r_j;
        w_hi_nxt     = r_hi;
        w_thresh_nxt = r_thresh;
        w_write      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_ST_INI: begin
                w_i_nxt  = '0;
                w_j_nxt  = '0;
                w_hi_nxt = '0;
                if (Start) begin
                    w_thresh_nxt = Thresh;
                    if (Mode) begin
                        w_state_nxt = c_ST_REV;
                        w_i_nxt     = c_LAST;
                    end else begin
                        w_state_nxt = c_ST_SCAN;
                    end
                end
            end
            c_ST_SCAN: begin
                // The first match becomes N[0]; with no match the pass wraps to I = 0
                w_write = w_match;
                w_i_nxt = f_inc(r_i);
                if (w_match) begin
                    w_j_nxt     = f_inc(r_j);
                    w_hi_nxt    = r_hi + (AW+1)'(1);
                    w_state_nxt = c_ST_COPY;
                end else if (r_i == c_LAST) begin
                    w_state_nxt = c_ST_COPY;
                end
            end
            c_ST_COPY: begin
                w_write = 1'b1;
                w_i_nxt = f_inc(r_i);
                w_j_nxt = f_inc(r_j);
                if (w_match) w_hi_nxt = r_hi + (AW+1)'(1);
                if (r_j == c_LAST) w_state_nxt = c_ST_DONE;
            end
            c_ST_REV: begin
                w_write = 1'b1;
                w_i_nxt = f_dec(r_i);
                w_j_nxt = f_inc(r_j);
                if (w_match) w_hi_nxt = r_hi + (AW+1)'(1);
                if (r_j == c_LAST) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                w_done = 1'b1;
                if (Ack) begin
                    w_state_nxt = c_ST_INI;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_hi_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_INI;
                w_i_nxt     = '0;
                w_j_nxt     = '0;
                w_hi_nxt    = '0;
            end
        endcase
    end

    assign I             = r_i;
    assign J             = r_j;
    assign Hi_Count      = r_hi;
    assign Ns_of_J_Write = w_write;
    assign Done          = w_done;

endmodule
`default_nettype wire

// File: tb/tb_copy_array_split_param.sv
`default_nettype none
// Bench for copy_array_split_param: a default-size instance for the directed
// vectors and a WIDTH=8/DEPTH=16 instance for randomized operations.
module tb_copy_array_split_param;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       Ack;
    logic       Mode;
    logic [7:0] thresh;
    logic       sel;

    logic [7:0] mem_m [16];
    logic [7:0] n_arr [16];
    int         n_op  [16];
    int         op_id  = 0;
    int         wr_cnt = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 Clk = ~Clk;

    logic [3:0] i_a, j_a, i_b, j_b, i_s, j_s;
    logic       wr_a, wr_b, wr_s, done_a, done_b, done_s;
    logic [4:0] hi_a, hi_b, hi_s;
    logic [3:0] ms_a;
    logic [7:0] ms_b;
    logic       start_a, start_b;

    assign ms_a    = mem_m[i_a][3:0];
    assign ms_b    = mem_m[i_b];
    assign start_a = Start & ~sel;
    assign start_b = Start & sel;
    assign i_s     = sel ? i_b : i_a;
    assign j_s     = sel ? j_b : j_a;
    assign wr_s    = sel ? wr_b : wr_a;
    assign done_s  = sel ? done_b : done_a;
    assign hi_s    = sel ? hi_b : hi_a;

    copy_array_split_param dut_a (
        .Clk(Clk), .Reset(Reset), .Start(start_a), .Ack(Ack), .Mode(Mode),
        .Thresh(thresh[3:0]), .Ms_of_I(ms_a), .I(i_a), .J(j_a),
        .Ns_of_J_Write(wr_a), .Done(done_a), .Hi_Count(hi_a)
    );

    copy_array_split_param #(.WIDTH(8), .DEPTH(16), .AW(4)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(start_b), .Ack(Ack), .Mode(Mode),
        .Thresh(thresh), .Ms_of_I(ms_b), .I(i_b), .J(j_b),
        .Ns_of_J_Write(wr_b), .Done(done_b), .Hi_Count(hi_b)
    );

    // The memory side of the selected instance: N[J] <= M[I] on a write strobe
    always @(posedge Clk) begin
        if (wr_s) begin
            n_arr[j_s] <= sel ? mem_m[i_s] : {4'h0, mem_m[i_s][3:0]};
            n_op[j_s]  <= op_id;
            wr_cnt     <= wr_cnt + 1;
        end
    end

    typedef struct {
        bit mode;
        int thr;
        int m [10];
        int n [10];
        int hi;
        int lat;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: result from the copy rules, not from any state sequence
    task automatic model(input int d, input bit mode, input int thr, input int mv [16],
                         output int en [16], output int hi, output int lat, output int first);
        int k;
        hi = 0;
        k  = -1;
        for (int x = 0; x < 16; x++) en[x] = 0;
        for (int x = 0; x < d; x++) begin
            if (mv[x] >= thr) begin
                hi++;
                if (k < 0) k = x;
            end
        end
        if (mode) begin
            for (int x = 0; x < d; x++) en[x] = mv[d-1-x];
            lat = d;  first = 1;
        end else if (k < 0) begin
            for (int x = 0; x < d; x++) en[x] = mv[x];
            lat = 2*d;  first = d + 1;
        end else begin
            for (int x = 0; x < d; x++) en[x] = mv[(k+x) % d];
            lat = k + d;  first = k + 1;
        end
    endtask

    task automatic mem_vals(input int d, output int mv [16]);
        for (int x = 0; x < 16; x++)
            mv[x] = (x < d) ? (sel ? int'(mem_m[x]) : int'(mem_m[x][3:0])) : 0;
    endtask

    task automatic run_op(input string tag, input bit mode, input int thr, input int d,
                          input int en [16], input int ehi, input int elat,
                          input int efirst, input bit perturb);
        int  base, cyc, first, bad_i, bad_n;
        bit  got;
        op_id++;
        @(negedge Clk);
        Mode   = mode;
        thresh = 8'(thr);
        Start  = 1'b1;
        @(posedge Clk);
        base = wr_cnt;
        #1 Start = 1'b0;
        cyc = 0;  first = 0;  bad_i = 0;  got = 1'b0;
        while (!got && cyc < 4*d + 8) begin
            if (perturb) begin
                thresh = 8'($urandom);
                Start  = ($urandom_range(0, 7) == 0);
                Mode   = ~mode;
            end
            @(posedge Clk);
            cyc++;
            #1;
            if (first == 0 && wr_cnt != base) first = cyc;
            if (int'(i_s) >= d) bad_i++;
            if (done_s) got = 1'b1;
        end
        Start = 1'b0;
        check({tag, " done_reached"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(elat));
        check({tag, " first_write_edge"}, 32'(first), 32'(efirst));
        check({tag, " write_count"}, 32'(wr_cnt - base), 32'(d));
        check({tag, " i_in_range"}, 32'(bad_i), 32'd0);
        check({tag, " hi_count"}, 32'(hi_s), 32'(ehi));
        bad_n = 0;
        for (int x = 0; x < d; x++) begin
            check($sformatf("%s n[%0d]", tag, x), 32'(n_arr[x]), 32'(en[x]));
            if (n_op[x] != op_id) bad_n++;
        end
        check({tag, " j_each_written"}, 32'(bad_n), 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        check({tag, " done_held"}, 32'(done_s), 32'd1);
        check({tag, " hi_held"}, 32'(hi_s), 32'(ehi));
        @(negedge Clk) Ack = 1'b1;
        @(posedge Clk);
        #1 Ack = 1'b0;
        check({tag, " ack_done_low"}, 32'(done_s), 32'd0);
        check({tag, " ini_idx"}, {24'd0, i_s, j_s}, 32'd0);
        check({tag, " ini_hi"}, 32'(hi_s), 32'd0);
    endtask

    // Start an operation, abort it with Reset once J reaches 4
    task automatic reset_at_j4(input string tag, input int thr);
        int base, cyc;
        @(negedge Clk);
        Mode   = 1'b0;
        thresh = 8'(thr);
        Start  = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        cyc = 0;
        while (j_s != 4'd4 && cyc < 40) begin
            @(posedge Clk);
            cyc++;
            #1;
        end
        check({tag, " reached_j4"}, 32'(j_s), 32'd4);
        base  = wr_cnt;
        Reset = 1'b1;
        #1;
        check({tag, " rst_idx"}, {24'd0, i_s, j_s}, 32'd0);
        check({tag, " rst_outs"}, {27'd0, hi_s, wr_s, done_s}, 32'd0);
        @(posedge Clk);
        #1;
        check({tag, " rst_no_write"}, 32'(wr_cnt - base), 32'd0);
        @(negedge Clk) Reset = 1'b0;
    endtask

    initial begin
        int mv [16];
        int en [16];
        int ehi, elat, efirst, thr, d;
        bit mode;

        vt[0] = '{mode: 1'b0, thr: 8,  m: '{1,3,5,7,9,10,11,12,14,15},
                  n: '{9,10,11,12,14,15,1,3,5,7}, hi: 6,  lat: 14};
        vt[1] = '{mode: 1'b0, thr: 0,  m: '{1,3,5,7,9,10,11,12,14,15},
                  n: '{1,3,5,7,9,10,11,12,14,15}, hi: 10, lat: 10};
        vt[2] = '{mode: 1'b0, thr: 15, m: '{1,3,5,7,9,10,11,12,14,15},
                  n: '{15,1,3,5,7,9,10,11,12,14}, hi: 1,  lat: 19};
        vt[3] = '{mode: 1'b0, thr: 12, m: '{0,1,2,3,4,5,6,7,8,9},
                  n: '{0,1,2,3,4,5,6,7,8,9},      hi: 0,  lat: 20};
        vt[4] = '{mode: 1'b1, thr: 5,  m: '{0,1,2,3,4,5,6,7,8,9},
                  n: '{9,8,7,6,5,4,3,2,1,0},      hi: 5,  lat: 10};

        Reset = 1'b1;  Start = 1'b0;  Ack = 1'b0;  Mode = 1'b0;
        thresh = 8'd0;  sel = 1'b0;
        for (int x = 0; x < 16; x++) mem_m[x] = 8'd0;
        #2;
        check("reset_a", {20'd0, i_a, j_a, hi_a, wr_a, done_a}, 32'd0);
        check("reset_b", {20'd0, i_b, j_b, hi_b, wr_b, done_b}, 32'd0);
        @(negedge Clk) Reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            for (int x = 0; x < 16; x++) mem_m[x] = (x < 10) ? 8'(vt[v].m[x]) : 8'd0;
            mem_vals(10, mv);
            model(10, vt[v].mode, vt[v].thr, mv, en, ehi, elat, efirst);
            for (int x = 0; x < 16; x++) en[x] = (x < 10) ? vt[v].n[x] : 0;
            run_op($sformatf("vec%0d", v), vt[v].mode, vt[v].thr, 10, en,
                   vt[v].hi, vt[v].lat, efirst, 1'b0);
        end

        for (int x = 0; x < 10; x++) mem_m[x] = 8'(vt[0].m[x]);
        reset_at_j4("abort_a", 8);

        sel = 1'b1;
        d   = 16;
        for (int x = 0; x < 16; x++) mem_m[x] = 8'(x * 16 + 3);
        reset_at_j4("abort_b", 100);
        mem_vals(d, mv);
        model(d, 1'b0, 100, mv, en, ehi, elat, efirst);
        run_op("rerun_b", 1'b0, 100, d, en, ehi, elat, efirst, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int x = 0; x < 16; x++) mem_m[x] = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       thr = 0;
                1:       thr = 255;
                default: thr = int'($urandom_range(0, 255));
            endcase
            mode = 1'($urandom_range(0, 1));
            mem_vals(d, mv);
            model(d, mode, thr, mv, en, ehi, elat, efirst);
            run_op($sformatf("rnd%0d", t), mode, thr, d, en, ehi, elat, efirst, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
